dsm_frac_ctrl: RTL and testbench
================================

DSM_FRAC_CTRL -- requirements
Module: dsm_frac_ctrl

Interface
REQ-001 Parameter W, default 16, fractional word width, equal to the width of the delta-sigma modulator's alpha input.
REQ-002 Parameter IW, default 8, integer divide-ratio width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cfg_valid  input  1  new configuration offered.
REQ-006 cfg_ready  output  1  controller can accept a configuration.
REQ-007 cfg_int  input  IW  target integer divide value.
REQ-008 cfg_frac  input  W  target fractional word.
REQ-009 cfg_step  input  W  ramp step per tick; 0 means jump directly to target.
REQ-010 tick  input  1  single-cycle pulse marking each feedback-divider cycle boundary.
REQ-011 dsm_carry  input  1  modulator MSB/carry output for the current divider cycle.
REQ-012 alpha  output  W  fractional word driven to the modulator, registered.
REQ-013 dsm_en  output  1  modulator enable, registered.
REQ-014 div_ratio  output  IW+1  instantaneous divide ratio, registered.
REQ-015 ramping  output  1  high while state is RAMP.
REQ-016 done  output  1  one-cycle pulse when alpha reaches target.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, RAMP and HOLD.
REQ-018 cfg_ready SHALL be 1 in IDLE and HOLD and 0 in LOAD and RAMP.
REQ-019 A handshake SHALL occur on a rising edge with cfg_valid=1 and cfg_ready=1.
  - The controller captures tgt_int, tgt_frac and step.
  - The next state is LOAD.
  - cfg_valid while cfg_ready=0 is ignored, with no capture.
REQ-020 LOAD SHALL wait for tick. On that tick:
  - int_reg <= tgt_int and dsm_en <= 1.
  - If step=0 or alpha=tgt_frac: alpha <= tgt_frac, go to HOLD.
  - Otherwise go to RAMP.
REQ-021 In RAMP, on each tick, alpha SHALL move toward tgt_frac by step.
  - If |tgt_frac-alpha| <= step: alpha <= tgt_frac, go to HOLD.
  - Difference and sum are computed in W+1 bits; alpha never wraps or overshoots.
REQ-022 alpha SHALL change only on cycles where tick=1 and SHALL hold its value otherwise.
REQ-023 done SHALL pulse high for exactly one cycle, on the edge that enters HOLD.
REQ-024 On every tick, div_ratio SHALL load int_reg + (dsm_en & dsm_carry), zero-extended to IW+1 bits.
  - int_reg and dsm_en are the values before that edge's update.
  - The sum can never overflow (max 2^IW).
REQ-025 A handshake on the same edge as a tick in HOLD SHALL be accepted.
  - div_ratio updates from the old int_reg on that edge.
  - The new configuration applies on the next tick, via LOAD.
REQ-026 A tick in IDLE SHALL update div_ratio only (to 0 after reset) and SHALL leave all other state unchanged.
REQ-027 dsm_en, once set, SHALL remain 1 until reset.

Reset
REQ-028 While rst=1, the block SHALL immediately and asynchronously force the following values:
  - state IDLE; alpha, int_reg, tgt_int, tgt_frac and step to 0.
  - div_ratio 0, dsm_en 0, ramping 0, done 0, cfg_ready 1.
REQ-029 Reset asserted mid-RAMP or mid-LOAD SHALL discard the pending configuration. No done pulse SHALL be produced.
REQ-030 After rst deasserts, the first handshake SHALL be accepted on the first qualifying rising edge.

Verification
REQ-031 Reset check: assert rst mid-run -> all outputs 0 and cfg_ready=1 within the same cycle, without waiting for a clk edge.
REQ-032 Jump: W=16, IW=8; configure cfg_int=20, cfg_frac=0xCCCD, cfg_step=0; pulse tick.
  - On that tick: alpha=0xCCCD, done pulses once, dsm_en=1.
  - Next tick with dsm_carry=1 -> div_ratio=21; with dsm_carry=0 -> div_ratio=20.
REQ-033 Ramp up: from alpha=0, configure target 0x0100 with step 0x0060.
  - Successive ticks give alpha 0x0060, 0x00C0, 0x0100.
  - ramping=1 until the third tick; done pulses on the third tick only.
REQ-034 Ramp down: from alpha=0x0100, configure target 0x0000 with step 0x0080.
  - Ticks give 0x0080, then 0x0000.
  - No underflow wrap to 0xFF80.
REQ-035 Handshake rules:
  - cfg_valid held during RAMP -> cfg_ready=0 and the target is unchanged.
  - Handshake coincident with tick in HOLD -> div_ratio uses the old integer; the new integer is visible after the following tick.
REQ-036 Reset mid-RAMP (alpha=0x00C0) -> alpha=0 and no done pulse.
  - A new configuration is accepted on the first edge after deassertion.

Source files
------------

// File: rtl/dsm_frac_ctrl_if.sv
// Configuration handshake and modulator-facing signals for dsm_frac_ctrl.
// The master side offers configurations and divider ticks; the slave side is the controller.
interface dsm_frac_ctrl_if #(
    parameter int W  = 16,
    parameter int IW = 8
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [IW-1:0] cfg_int;
    logic [W-1:0]  cfg_frac;
    logic [W-1:0]  cfg_step;
    logic          tick;
    logic          dsm_carry;
    logic [W-1:0]  alpha;
    logic          dsm_en;
    logic [IW:0]   div_ratio;
    logic          ramping;
    logic          done;

    modport master (
        output cfg_valid, cfg_int, cfg_frac, cfg_step, tick, dsm_carry,
        input  cfg_ready, alpha, dsm_en, div_ratio, ramping, done
    );

    modport slave (
        input  cfg_valid, cfg_int, cfg_frac, cfg_step, tick, dsm_carry,
        output cfg_ready, alpha, dsm_en, div_ratio, ramping, done
    );
endinterface

// File: rtl/dsm_frac_ctrl.sv
// Fractional-N delta-sigma controller: accepts a target divide value and glides the
// modulator's fractional word toward it, one step per feedback-divider tick.
module dsm_frac_ctrl #(
    parameter int W  = 16,
    parameter int IW = 8
) (
    input  logic             clk,
    input  logic             rst,
    dsm_frac_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RAMP, HOLD} state_t;

    state_t        state, nxt;
    logic [W-1:0]  alpha_q, alpha_d, tgt_frac, step;
    logic [IW-1:0] int_reg, tgt_int;
    logic [IW:0]   div_q;
    logic          en_q, en_d, done_q, done_d, ld_int;
    logic          hs, rdy, up;
    logic [W:0]    diff;

    assign rdy = (state == IDLE) || (state == HOLD);
    assign hs  = bus.cfg_valid && rdy;
    // Distance to target in W+1 bits so the last step snaps instead of wrapping.
    assign up   = tgt_frac > alpha_q;
    assign diff = up ? ({1'b0, tgt_frac} - {1'b0, alpha_q})
                     : ({1'b0, alpha_q} - {1'b0, tgt_frac});

    always_comb begin
        nxt     = state;
        alpha_d = alpha_q;
        en_d    = en_q;
        done_d  = 1'b0;
        ld_int  = 1'b0;
        case (state)
            IDLE, HOLD: if (hs) nxt = LOAD;
            LOAD: if (bus.tick) begin
                ld_int = 1'b1;
                en_d   = 1'b1;
                if (step == '0 || alpha_q == tgt_frac) begin
                    alpha_d = tgt_frac;
                    done_d  = 1'b1;
                    nxt     = HOLD;
                end else begin
                    nxt = RAMP;
                end
            end
            RAMP: if (bus.tick) begin
                if (diff <= {1'b0, step}) begin
                    alpha_d = tgt_frac;
                    done_d  = 1'b1;
                    nxt     = HOLD;
                end else begin
                    alpha_d = up ? alpha_q + step : alpha_q - step;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            alpha_q  <= '0;
            int_reg  <= '0;
            tgt_int  <= '0;
            tgt_frac <= '0;
            step     <= '0;
            div_q    <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state   <= nxt;
            alpha_q <= alpha_d;
            en_q    <= en_d;
            done_q  <= done_d;
            if (hs) begin
                tgt_int  <= bus.cfg_int;
                tgt_frac <= bus.cfg_frac;
                step     <= bus.cfg_step;
            end
            if (ld_int) int_reg <= tgt_int;
            // Uses pre-edge int_reg/en so a coincident reload lands one tick later.
            if (bus.tick)
                div_q <= {1'b0, int_reg} + {{IW{1'b0}}, en_q & bus.dsm_carry};
        end
    end

    assign bus.cfg_ready = rdy;
    assign bus.alpha     = alpha_q;
    assign bus.dsm_en    = en_q;
    assign bus.div_ratio = div_q;
    assign bus.ramping   = (state == RAMP);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_dsm_frac_ctrl.sv
// Directed-vector bench for dsm_frac_ctrl (W=16, IW=8).
module tb_dsm_frac_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    dsm_frac_ctrl_if #(.W(16), .IW(8)) bus ();

    dsm_frac_ctrl #(.W(16), .IW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_valid = 1'b0;
        bus.cfg_int   = '0;
        bus.cfg_frac  = '0;
        bus.cfg_step  = '0;
        bus.tick      = 1'b0;
        bus.dsm_carry = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        nvec++; if (bus.alpha !== 16'h0) begin nerr++; $display("FAIL rst_alpha got %h want 0000", bus.alpha); end
        nvec++; if (bus.dsm_en !== 1'b0) begin nerr++; $display("FAIL rst_en got %b want 0", bus.dsm_en); end
        nvec++; if (bus.div_ratio !== 9'd0) begin nerr++; $display("FAIL rst_div got %0d want 0", bus.div_ratio); end
        nvec++; if (bus.cfg_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready got %b want 1", bus.cfg_ready); end
        nvec++; if ({bus.ramping, bus.done} !== 2'b00) begin nerr++; $display("FAIL rst_flags got %b want 00", {bus.ramping, bus.done}); end
        cyc();
        rst = 1'b0;
        // tick in IDLE touches only div_ratio, which stays 0
        bus.tick = 1'b1; bus.dsm_carry = 1'b1;
        cyc();
        bus.tick = 1'b0; bus.dsm_carry = 1'b0;
        nvec++; if ({bus.alpha, bus.dsm_en, bus.div_ratio} !== 26'd0) begin nerr++; $display("FAIL idle_tick got %h/%b/%0d want 0/0/0", bus.alpha, bus.dsm_en, bus.div_ratio); end
    endtask

    task automatic test_jump();
        bus.cfg_valid = 1'b1; bus.cfg_int = 8'd20; bus.cfg_frac = 16'hCCCD; bus.cfg_step = 16'h0;
        cyc();
        bus.cfg_valid = 1'b0;
        nvec++; if (bus.cfg_ready !== 1'b0) begin nerr++; $display("FAIL jump_load_ready got %b want 0", bus.cfg_ready); end
        cyc();
        nvec++; if (bus.alpha !== 16'h0) begin nerr++; $display("FAIL jump_no_tick_alpha got %h want 0000", bus.alpha); end
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        nvec++; if (bus.alpha !== 16'hCCCD) begin nerr++; $display("FAIL jump_alpha got %h want cccd", bus.alpha); end
        nvec++; if (bus.done !== 1'b1) begin nerr++; $display("FAIL jump_done got %b want 1", bus.done); end
        nvec++; if (bus.dsm_en !== 1'b1) begin nerr++; $display("FAIL jump_en got %b want 1", bus.dsm_en); end
        nvec++; if (bus.div_ratio !== 9'd0) begin nerr++; $display("FAIL jump_div_old got %0d want 0", bus.div_ratio); end
        cyc();
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL jump_done_once got %b want 0", bus.done); end
        bus.tick = 1'b1; bus.dsm_carry = 1'b1;
        cyc();
        nvec++; if (bus.div_ratio !== 9'd21) begin nerr++; $display("FAIL jump_div_c1 got %0d want 21", bus.div_ratio); end
        bus.dsm_carry = 1'b0;
        cyc();
        bus.tick = 1'b0;
        nvec++; if (bus.div_ratio !== 9'd20) begin nerr++; $display("FAIL jump_div_c0 got %0d want 20", bus.div_ratio); end
    endtask

    task automatic test_ramp_up();
        logic [15:0] exp_a [3];
        exp_a[0] = 16'h0060; exp_a[1] = 16'h00C0; exp_a[2] = 16'h0100;
        apply_reset();
        bus.cfg_valid = 1'b1; bus.cfg_int = 8'd5; bus.cfg_frac = 16'h0100; bus.cfg_step = 16'h0060;
        cyc();
        // keep offering a different config while busy; it must be ignored
        bus.cfg_frac = 16'h0F00; bus.cfg_int = 8'd99;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        nvec++; if (bus.ramping !== 1'b1 || bus.alpha !== 16'h0) begin nerr++; $display("FAIL up_enter got ramp=%b alpha=%h want 1/0000", bus.ramping, bus.alpha); end
        nvec++; if (bus.cfg_ready !== 1'b0) begin nerr++; $display("FAIL up_busy_ready got %b want 0", bus.cfg_ready); end
        for (int i = 0; i < 3; i++) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            if (i == 2) bus.cfg_valid = 1'b0;
            nvec++; if (bus.alpha !== exp_a[i]) begin nerr++; $display("FAIL up_alpha%0d got %h want %h", i, bus.alpha, exp_a[i]); end
            nvec++; if (bus.ramping !== (i != 2)) begin nerr++; $display("FAIL up_ramping%0d got %b want %b", i, bus.ramping, i != 2); end
            nvec++; if (bus.done !== (i == 2)) begin nerr++; $display("FAIL up_done%0d got %b want %b", i, bus.done, i == 2); end
            cyc();
            nvec++; if (bus.alpha !== exp_a[i]) begin nerr++; $display("FAIL up_hold%0d got %h want %h", i, bus.alpha, exp_a[i]); end
        end
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL up_done_once got %b want 0", bus.done); end
    endtask

    task automatic test_ramp_down();
        bus.cfg_valid = 1'b1; bus.cfg_int = 8'd7; bus.cfg_frac = 16'h0000; bus.cfg_step = 16'h0080;
        cyc();
        bus.cfg_valid = 1'b0;
        bus.tick = 1'b1;
        cyc();
        nvec++; if (bus.div_ratio !== 9'd5) begin nerr++; $display("FAIL dn_div_old got %0d want 5", bus.div_ratio); end
        cyc();
        nvec++; if (bus.alpha !== 16'h0080) begin nerr++; $display("FAIL dn_alpha0 got %h want 0080", bus.alpha); end
        nvec++; if (bus.div_ratio !== 9'd7) begin nerr++; $display("FAIL dn_div_new got %0d want 7", bus.div_ratio); end
        cyc();
        bus.tick = 1'b0;
        nvec++; if (bus.alpha !== 16'h0000) begin nerr++; $display("FAIL dn_alpha1 got %h want 0000", bus.alpha); end
        nvec++; if (bus.done !== 1'b1 || bus.ramping !== 1'b0) begin nerr++; $display("FAIL dn_done got done=%b ramp=%b want 1/0", bus.done, bus.ramping); end
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        nvec++; if (bus.alpha !== 16'h0000) begin nerr++; $display("FAIL dn_no_wrap got %h want 0000", bus.alpha); end
    endtask

    task automatic test_back_to_back();
        bus.cfg_valid = 1'b1; bus.cfg_int = 8'd9; bus.cfg_frac = 16'h0200; bus.cfg_step = 16'h0;
        bus.tick = 1'b1; bus.dsm_carry = 1'b1;
        cyc();
        bus.cfg_valid = 1'b0; bus.dsm_carry = 1'b0;
        nvec++; if (bus.div_ratio !== 9'd8) begin nerr++; $display("FAIL b2b_div_old got %0d want 8", bus.div_ratio); end
        nvec++; if (bus.cfg_ready !== 1'b0) begin nerr++; $display("FAIL b2b_accept got ready=%b want 0", bus.cfg_ready); end
        cyc();
        nvec++; if (bus.div_ratio !== 9'd7 || bus.alpha !== 16'h0200) begin nerr++; $display("FAIL b2b_load got div=%0d alpha=%h want 7/0200", bus.div_ratio, bus.alpha); end
        cyc();
        bus.tick = 1'b0;
        nvec++; if (bus.div_ratio !== 9'd9) begin nerr++; $display("FAIL b2b_div_new got %0d want 9", bus.div_ratio); end
    endtask

    task automatic test_reset_mid_ramp();
        apply_reset();
        bus.cfg_valid = 1'b1; bus.cfg_int = 8'd4; bus.cfg_frac = 16'h0100; bus.cfg_step = 16'h0060;
        cyc();
        bus.cfg_valid = 1'b0;
        bus.tick = 1'b1;
        cyc(); cyc(); cyc();
        bus.tick = 1'b0;
        nvec++; if (bus.alpha !== 16'h00C0 || bus.ramping !== 1'b1) begin nerr++; $display("FAIL mid_pre got alpha=%h ramp=%b want 00c0/1", bus.alpha, bus.ramping); end
        #2;
        rst = 1'b1;
        #1;
        nvec++; if ({bus.alpha, bus.dsm_en, bus.div_ratio, bus.ramping, bus.done} !== 28'd0) begin nerr++; $display("FAIL mid_async got alpha=%h en=%b div=%0d ramp=%b done=%b want all 0", bus.alpha, bus.dsm_en, bus.div_ratio, bus.ramping, bus.done); end
        nvec++; if (bus.cfg_ready !== 1'b1) begin nerr++; $display("FAIL mid_ready got %b want 1", bus.cfg_ready); end
        bus.tick = 1'b1;
        cyc();
        cyc();
        bus.tick = 1'b0;
        nvec++; if (bus.done !== 1'b0 || bus.alpha !== 16'h0) begin nerr++; $display("FAIL mid_no_done got done=%b alpha=%h want 0/0000", bus.done, bus.alpha); end
        rst = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_int = 8'd3; bus.cfg_frac = 16'h1234; bus.cfg_step = 16'h0;
        cyc();
        bus.cfg_valid = 1'b0;
        nvec++; if (bus.cfg_ready !== 1'b0) begin nerr++; $display("FAIL post_accept got ready=%b want 0", bus.cfg_ready); end
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        nvec++; if (bus.alpha !== 16'h1234 || bus.done !== 1'b1) begin nerr++; $display("FAIL post_jump got alpha=%h done=%b want 1234/1", bus.alpha, bus.done); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_ramp_up();
        test_ramp_down();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
